// File: rtl/array_pkg.sv
// Shared types and default sizing for the LSTM array sequencer.
// Optional feature macro: ARRAY_CTRL_BPTT_EN (backward-pass state).
package array_pkg;

   localparam int unsigned NUM_ITERATIONS_DEF = 8;
   localparam int unsigned STEP_CYCLES_DEF    = 44;
   localparam int unsigned IDX_W_DEF          = 4;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StLoad,
      StBwd,
      StDone
   } state_e;

endpackage

// File: rtl/array_ctrl_if.sv
// Control/status bundle between the sequencer and its requester.
import array_pkg::*;

interface array_ctrl_if #(
   parameter int unsigned IDX_W = IDX_W_DEF
);
   logic             start;
   logic             stall;
   logic             abort;
   logic             load;
   logic             sel;
   logic [IDX_W-1:0] step;
   logic             busy;
   logic             done;
   logic             bp_en;
   logic [IDX_W-1:0] bp_step;

   modport master (
      output start, stall, abort,
      input  load, sel, step, busy, done, bp_en, bp_step
   );

   modport slave (
      input  start, stall, abort,
      output load, sel, step, busy, done, bp_en, bp_step
   );
endinterface

// File: rtl/array_step_timer.sv
// Stall-gated per-timestep cycle counter with terminal-count flag.
// Wraps to zero on the terminal count so RUN and BWD can chain steps.
module array_step_timer
   import array_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = STEP_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_stall,
   output logic o_tc
);

   localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_tc;

   assign w_tc = (r_cnt == CNT_W'(STEP_CYCLES - 1));
   assign o_tc = w_tc;

   // Next count: clear wins, otherwise advance only when enabled and not stalled.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_clr) begin
         w_cnt_nxt = '0;
      end else if (i_en && !i_stall) begin
         w_cnt_nxt = w_tc ? '0 : r_cnt + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_nxt;
      end
   end

endmodule

// File: rtl/array_ctrl.sv
// LSTM systolic-array sequencer: forward timesteps with weight-load strobes,
// optional backward pass (enabled by macro ARRAY_CTRL_BPTT_EN), abort and stall.
module array_ctrl
   import array_pkg::*;
#(
   parameter int unsigned NUM_ITERATIONS = NUM_ITERATIONS_DEF,
   parameter int unsigned STEP_CYCLES    = STEP_CYCLES_DEF,
   parameter int unsigned IDX_W          = IDX_W_DEF
) (
   input logic         clk,
   input logic         rst,
   array_ctrl_if.slave bus
);

   localparam logic [IDX_W-1:0] LastStep = IDX_W'(NUM_ITERATIONS - 1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [IDX_W-1:0] r_step;
   logic [IDX_W-1:0] w_step_nxt;
   logic             w_cnt_en;
   logic             w_tc;
   logic             w_adv;

`ifdef ARRAY_CTRL_BPTT_EN
   logic [IDX_W-1:0] r_bp_step;
   logic [IDX_W-1:0] w_bp_step_nxt;
   assign w_cnt_en = (r_state == StRun) || (r_state == StBwd);
`else
   assign w_cnt_en = (r_state == StRun);
`endif

   // A timestep finishes on the terminal count only if not stalled.
   assign w_adv = w_tc && !bus.stall;

   array_step_timer #(
      .STEP_CYCLES (STEP_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (!w_cnt_en),
      .i_en    (w_cnt_en),
      .i_stall (bus.stall),
      .o_tc    (w_tc)
   );

   // Next-state and index update; abort overrides everything outside IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_step_nxt  = r_step;
`ifdef ARRAY_CTRL_BPTT_EN
      w_bp_step_nxt = r_bp_step;
`endif
      unique case (r_state)
         StIdle: begin
            if (bus.start && !bus.abort) w_state_nxt = StRun;
         end
         StRun: begin
            if (w_adv) w_state_nxt = StLoad;
         end
         StLoad: begin
            if (r_step == LastStep) begin
`ifdef ARRAY_CTRL_BPTT_EN
               w_state_nxt   = StBwd;
               w_bp_step_nxt = LastStep;
`else
               w_state_nxt = StDone;
`endif
            end else begin
               w_step_nxt  = r_step + 1'b1;
               w_state_nxt = StRun;
            end
         end
`ifdef ARRAY_CTRL_BPTT_EN
         StBwd: begin
            if (w_adv) begin
               if (r_bp_step == '0) w_state_nxt = StDone;
               else w_bp_step_nxt = r_bp_step - 1'b1;
            end
         end
`endif
         StDone: begin
            w_state_nxt = StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
      if (bus.abort && (r_state != StIdle)) w_state_nxt = StIdle;
      // Indices are already zero on the first IDLE cycle, including after abort.
      if (w_state_nxt == StIdle) begin
         w_step_nxt = '0;
`ifdef ARRAY_CTRL_BPTT_EN
         w_bp_step_nxt = '0;
`endif
      end
   end

   // State and index registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= StIdle;
         r_step  <= '0;
`ifdef ARRAY_CTRL_BPTT_EN
         r_bp_step <= '0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_step  <= w_step_nxt;
`ifdef ARRAY_CTRL_BPTT_EN
         r_bp_step <= w_bp_step_nxt;
`endif
      end
   end

   // Moore outputs; sel picks the recurrent path for every step but the first.
   assign bus.load = (r_state == StLoad);
   assign bus.sel  = (r_state == StLoad) && (r_step != '0);
   assign bus.step = r_step;
   assign bus.busy = (r_state != StIdle);
   assign bus.done = (r_state == StDone);
`ifdef ARRAY_CTRL_BPTT_EN
   assign bus.bp_en   = (r_state == StBwd);
   assign bus.bp_step = r_bp_step;
`else
   assign bus.bp_en   = 1'b0;
   assign bus.bp_step = '0;
`endif

endmodule

// File: tb/tb_array_ctrl.sv
// Directed bench for array_ctrl (NUM_ITERATIONS=8, STEP_CYCLES=44).
// Honours ARRAY_CTRL_BPTT_EN for the backward-pass expectations.
module tb_array_ctrl;

   localparam int unsigned NI = 8;
   localparam int unsigned SC = 44;
   localparam int unsigned IW = 4;

`ifdef ARRAY_CTRL_BPTT_EN
   localparam bit BPTT   = 1'b1;
   localparam int DONE_E = 713;
`else
   localparam bit BPTT   = 1'b0;
   localparam int DONE_E = 361;
`endif

   logic        clk;
   logic        rst;
   int          vectors;
   int          miscompares;
   logic [12:0] w_obs;

   array_ctrl_if #(.IDX_W(IW)) bus ();

   array_ctrl #(
      .NUM_ITERATIONS (NI),
      .STEP_CYCLES    (SC),
      .IDX_W          (IW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign w_obs = {bus.busy, bus.load, bus.sel, bus.done, bus.bp_en, bus.step, bus.bp_step};

   // Expected outputs seen at edge e, where the start was sampled at edge 0.
   function automatic logic [12:0] exp_vec(input int e);
      logic       x_busy, x_load, x_sel, x_done, x_bpen;
      logic [3:0] x_step, x_bps;
      x_busy = 1'b0; x_load = 1'b0; x_sel = 1'b0; x_done = 1'b0; x_bpen = 1'b0;
      x_step = 4'd0; x_bps = 4'd0;
      if (e >= 1 && e <= DONE_E) begin
         x_busy = 1'b1;
         if (e <= 360) begin
            x_load = (e % 45 == 0);
            x_sel  = x_load && (e != 45);
            x_step = 4'((e - 1) / 45);
         end else begin
            x_step = 4'd7;
         end
         x_done = (e == DONE_E);
         if (BPTT && e >= 361 && e <= 712) begin
            x_bpen = 1'b1;
            x_bps  = 4'(7 - (e - 361) / 44);
         end
      end
      return {x_busy, x_load, x_sel, x_done, x_bpen, x_step, x_bps};
   endfunction

   task automatic do_reset();
      rst = 1'b0;
      bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [12:0] x;
      rst = 1'b0;
      bus.start = 1'b0; bus.stall = 1'b0; bus.abort = 1'b0;
      for (int n = 0; n <= 60; n++) begin
         @(negedge clk);
         x = exp_vec(n);
         vectors++;
         if (w_obs !== x) begin
            miscompares++;
            $display("FAIL reset_run cyc=%0d got=%h want=%h", n, w_obs, x);
         end
         rst = 1'b1;
         bus.start = (n == 0);
      end
      #2 rst = 1'b0;
      #1;
      vectors++;
      if (w_obs !== 13'd0) begin
         miscompares++;
         $display("FAIL async_reset got=%h want=%h", w_obs, 13'd0);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         vectors++;
         if (w_obs !== 13'd0) begin
            miscompares++;
            $display("FAIL reset_hold k=%0d got=%h want=%h", k, w_obs, 13'd0);
         end
      end
   endtask

   task automatic test_forward();
      logic [12:0] x;
      do_reset();
      for (int n = 0; n <= DONE_E + 3; n++) begin
         @(negedge clk);
         x = exp_vec(n);
         vectors++;
         if (w_obs !== x) begin
            miscompares++;
            $display("FAIL forward cyc=%0d got=%h want=%h", n, w_obs, x);
         end
         bus.start = (n == 0);
      end
   endtask

   task automatic test_ignore_start();
      logic [12:0] x;
      do_reset();
      for (int n = 0; n <= DONE_E + 3; n++) begin
         @(negedge clk);
         x = exp_vec(n);
         vectors++;
         if (w_obs !== x) begin
            miscompares++;
            $display("FAIL ignore_start cyc=%0d got=%h want=%h", n, w_obs, x);
         end
         bus.start = (n == 0) || (n == 10) || (n == 200) || (n == 500);
      end
   endtask

   task automatic test_stall();
      logic [12:0] x;
      int          k;
      do_reset();
      for (int n = 0; n <= DONE_E + 13; n++) begin
         @(negedge clk);
         k = n - 50;
         if (k < 0) k = 0;
         if (k > 10) k = 10;
         x = exp_vec(n - k);
         vectors++;
         if (w_obs !== x) begin
            miscompares++;
            $display("FAIL stall cyc=%0d got=%h want=%h", n, w_obs, x);
         end
         bus.start = (n == 0);
         bus.stall = (n >= 50) && (n <= 59);
      end
      bus.stall = 1'b0;
   endtask

   task automatic test_abort();
      logic [12:0] x;
      int          e;
      do_reset();
      for (int n = 0; n <= 200; n++) begin
         @(negedge clk);
         if (n <= 100) e = n;
         else if (n <= 105) e = 0;
         else if (n <= 194) e = n - 105;
         else e = 0;
         x = exp_vec(e);
         vectors++;
         if (w_obs !== x) begin
            miscompares++;
            $display("FAIL abort cyc=%0d got=%h want=%h", n, w_obs, x);
         end
         bus.start = (n == 0) || (n == 105);
         // Abort must win over a simultaneous stall and over a terminal count.
         bus.abort = (n == 100) || (n == 194);
         bus.stall = (n == 100);
      end
      bus.start = 1'b0; bus.abort = 1'b0; bus.stall = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      bus.start   = 1'b0;
      bus.stall   = 1'b0;
      bus.abort   = 1'b0;
      test_reset();
      test_forward();
      test_ignore_start();
      test_stall();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/array_ctrl.md
ARRAY_CTRL -- requirements
Module: array_ctrl

Interface
REQ-001 SHALL have parameter NUM_ITERATIONS, default 8: LSTM timesteps per sequence.
REQ-002 SHALL have parameter STEP_CYCLES, default 44: compute cycles per timestep before each load.
REQ-003 SHALL have parameter IDX_W, default 4: width of step indices; must satisfy 2^IDX_W >= NUM_ITERATIONS.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  sequence request; sampled in IDLE only.
REQ-007 SHALL have port stall  input  1  freezes the step-cycle counter while high.
REQ-008 SHALL have port abort  input  1  cancels the current sequence.
REQ-009 SHALL have port load  output  1  one-cycle strobe committing array weights/state.
REQ-010 SHALL have port sel  output  1  array input select: 0 = fresh input, 1 = recurrent h.
REQ-011 SHALL have port step  output  IDX_W  current forward timestep index.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle completion pulse.
REQ-014 SHALL have port bp_en  output  1  backward pass active.
REQ-015 SHALL have port bp_step  output  IDX_W  backward timestep index.

Function
REQ-016 SHALL implement states IDLE, RUN, LOAD, BWD, DONE; all outputs Moore-decoded from registered state and counters.
REQ-017 IDLE: start=1 and abort=0 SHALL enter RUN next cycle with cycle count 0 and step 0.
REQ-018 RUN: count SHALL increment only when stall=0; at count STEP_CYCLES-1 with stall=0 SHALL enter LOAD.
REQ-019 LOAD SHALL last exactly one cycle, ignore stall, drive load=1 and sel=(step!=0).
REQ-020 Leaving LOAD with step<NUM_ITERATIONS-1 SHALL increment step, clear count, return to RUN.
REQ-021 Leaving LOAD with step=NUM_ITERATIONS-1 SHALL enter BWD if enabled (REQ-030), else DONE.
REQ-022 sel and load SHALL be 0 in every state other than LOAD.
REQ-023 DONE SHALL drive done=1 for one cycle, then enter IDLE; step returns to 0.
REQ-024 abort=1 in any non-IDLE state SHALL force IDLE next cycle; no done, no load; abort outranks stall and terminal count.
REQ-025 start while busy SHALL be ignored, not queued.
REQ-026 First load SHALL occur STEP_CYCLES+1 cycles after the start-sampling edge; forward pass spans NUM_ITERATIONS*(STEP_CYCLES+1) cycles.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, counts 0, step 0, bp_step 0, and load, sel, busy, done, bp_en all 0.
REQ-028 Reset mid-sequence SHALL discard progress; no done or load produced.
REQ-029 Reset release SHALL be effective on the first rising clk edge after rst=1.

Configuration
REQ-030 Macro ARRAY_CTRL_BPTT_EN defined: BWD state present; bp_en=1 in BWD; bp_step starts NUM_ITERATIONS-1, decrements after each STEP_CYCLES stall-gated cycles; after bp_step 0 completes enter DONE.
REQ-031 Macro undefined: no BWD logic; bp_en and bp_step tied 0.

Structure
REQ-032 Package array_pkg SHALL hold the state typedef and default values of NUM_ITERATIONS and STEP_CYCLES.
REQ-033 Sub-module array_step_timer SHALL provide the stall-gated, clearable count with terminal-count flag, shared by RUN and BWD.

Verification (NUM_ITERATIONS=8, STEP_CYCLES=44; start sampled at edge 0)
REQ-034 Reset asserted mid-RUN -> all outputs 0 immediately, IDLE; no load.
REQ-035 Start, no stall, macro off -> busy from cycle 1; load at cycles 45,90,...,360; sel=0 at 45, 1 at others; done at 361; IDLE 362.
REQ-036 Stall high cycles 50-59 -> loads at 45, then 100,145,...,370; done at 371.
REQ-037 Abort at cycle 100 -> IDLE at 101, no done; start at 105 -> first load at 150 with sel=0.
REQ-038 Start pulses at cycles 10 and 200 while busy -> ignored; load timing identical to REQ-035.
REQ-039 Macro on -> bp_en cycles 361-712, bp_step 7 down to 0 each 44 cycles; done at 713.
